// File: rtl/qtr_pkg.sv
// Shared definitions for the QTR reflectance-sensor decay-time measurement block.
package qtr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CHARGE    = 2'd1,
    ST_DISCHARGE = 2'd2,
    ST_DONE      = 2'd3
  } qtr_state_e;

  localparam logic [7:0] COUNT_MAX = 8'd255;

  // Clock cycles per 10 us measurement tick.
  function automatic int unsigned tick_10us_div(input int unsigned clk_freq);
    return clk_freq / 100_000;
  endfunction

  function automatic int unsigned charge_cycles(input int unsigned clk_freq,
                                                input int unsigned charge_us);
    return (clk_freq / 1_000_000) * charge_us;
  endfunction

  // Rounded mean of two counts, carried in 9 bits so the sum cannot overflow.
  function automatic logic [7:0] avg_round(input logic [7:0] prev, input logic [7:0] cur);
    logic [8:0] sum;
    sum = {1'b0, prev} + {1'b0, cur} + 9'd1;
    return sum[8:1];
  endfunction

endpackage

// File: rtl/qtr_measure_tick_gen.sv
// Restartable strobe generator: one-cycle tick every DIV cycles while run is high.
module qtr_tick_gen #(
  parameter int unsigned DIV = 600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic tick
);

  localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Phase counter; restart pins the first tick to DIV cycles after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (restart) begin
      cnt_r <= '0;
    end else if (run) begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = run && (cnt_r == LAST);

endmodule

// File: rtl/qtr_measure.sv
// QTR sensor decay-time measurement: charge, then count 10 us ticks until each pin reads low.
// Optional build macro QTR_AVG_EN: report the rounded mean of the previous and new result.
module qtr_measure
  import qtr_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 60_000_000,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned CHARGE_US     = 10
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset_n,
  input  logic                  en,
  output logic                  busy,
  output logic [NUM_CH*8-1:0]   value,
  output logic                  valid,
  output logic [NUM_CH-1:0]     qtr_out_en,
  output logic [NUM_CH-1:0]     qtr_out_sig,
  input  logic [NUM_CH-1:0]     qtr_in_sig,
  output logic [NUM_CH-1:0]     qtr_ctrl
);

  localparam int unsigned TICK_10US_DIV = tick_10us_div(CLK_FREQUENCY);
  localparam int unsigned CHARGE_CYC    = charge_cycles(CLK_FREQUENCY, CHARGE_US);
  localparam int unsigned CCW           = $clog2(CHARGE_CYC + 1);
  localparam logic [CCW-1:0] CHARGE_LAST = CCW'(CHARGE_CYC - 1);

  qtr_state_e                 state_r, state_next;
  logic [CCW-1:0]             charge_cnt_r;
  logic [NUM_CH-1:0]          sync1_r, sync_r, done_r, done_s;
  logic [NUM_CH-1:0][7:0]     count_r, value_r;
  logic                       charge_last_s, dis_entry_s, load_s, all_done_s, tick_s;
  logic                       busy_s, valid_s, drive_s, ctrl_s;
  logic                       busy_r, valid_r, drive_r, ctrl_r;

  assign charge_last_s = (charge_cnt_r == CHARGE_LAST);
  assign dis_entry_s   = (state_r == ST_CHARGE) && (state_next == ST_DISCHARGE);
  assign load_s        = (state_next == ST_DONE);
  assign all_done_s    = &done_s;

  // Two-flop synchronizer on the asynchronous pin readback.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      sync1_r <= '0;
      sync_r  <= '0;
    end else begin
      sync1_r <= qtr_in_sig;
      sync_r  <= sync1_r;
    end
  end

  // State register.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic; en only matters in IDLE.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE:      if (en) state_next = ST_CHARGE; else state_next = ST_IDLE;
      ST_CHARGE:    if (charge_last_s) state_next = ST_DISCHARGE; else state_next = ST_CHARGE;
      ST_DISCHARGE: if (all_done_s) state_next = ST_DONE; else state_next = ST_DISCHARGE;
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered pins track state_r exactly.
  always_comb begin
    busy_s  = 1'b0;
    valid_s = 1'b0;
    drive_s = 1'b0;
    ctrl_s  = 1'b0;
    case (state_next)
      ST_IDLE:      begin busy_s = 1'b0; ctrl_s = 1'b0; end
      ST_CHARGE:    begin busy_s = 1'b1; drive_s = 1'b1; ctrl_s = 1'b1; end
      ST_DISCHARGE: begin busy_s = 1'b1; ctrl_s = 1'b1; end
      ST_DONE:      begin busy_s = 1'b1; valid_s = 1'b1; end
      default:      begin busy_s = 1'b0; ctrl_s = 1'b0; end
    endcase
  end

  // Output registers.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      drive_r <= 1'b0;
      ctrl_r  <= 1'b0;
    end else begin
      busy_r  <= busy_s;
      valid_r <= valid_s;
      drive_r <= drive_s;
      ctrl_r  <= ctrl_s;
    end
  end

  // Charge-phase duration counter, idle at zero outside CHARGE.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      charge_cnt_r <= '0;
    end else if ((state_r == ST_CHARGE) && !charge_last_s) begin
      charge_cnt_r <= charge_cnt_r + CCW'(1);
    end else begin
      charge_cnt_r <= '0;
    end
  end

  qtr_tick_gen #(.DIV(TICK_10US_DIV)) u_tick (
    .clk     (hba_clk),
    .rst_n   (hba_reset_n),
    .restart (dis_entry_s),
    .run     (state_r == ST_DISCHARGE),
    .tick    (tick_s)
  );

  // A channel is finished once its pin reads low or its count saturates.
  always_comb begin
    done_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      done_s[k] = done_r[k] | ~sync_r[k] | (count_r[k] == COUNT_MAX);
    end
  end

  // Per-channel decay counters; a finished channel stays frozen.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      count_r <= '0;
      done_r  <= '0;
    end else if (dis_entry_s) begin
      count_r <= '0;
      done_r  <= '0;
    end else if (state_r == ST_DISCHARGE) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (done_s[k]) begin
          done_r[k] <= 1'b1;
        end else if (tick_s) begin
          count_r[k] <= count_r[k] + 8'd1;
        end else begin
          count_r[k] <= count_r[k];
        end
      end
    end else begin
      count_r <= count_r;
      done_r  <= done_r;
    end
  end

`ifdef QTR_AVG_EN
  logic have_r;

  // Marks that value holds a real result, so the first one is loaded raw.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      have_r <= 1'b0;
    end else if (load_s) begin
      have_r <= 1'b1;
    end else begin
      have_r <= have_r;
    end
  end
`endif

  // Result register, updated on the edge that enters DONE.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      value_r <= '0;
    end else if (load_s) begin
      for (int k = 0; k < NUM_CH; k++) begin
`ifdef QTR_AVG_EN
        value_r[k] <= have_r ? avg_round(value_r[k], count_r[k]) : count_r[k];
`else
        value_r[k] <= count_r[k];
`endif
      end
    end else begin
      value_r <= value_r;
    end
  end

  assign busy        = busy_r;
  assign valid       = valid_r;
  assign value       = value_r;
  assign qtr_out_en  = {NUM_CH{drive_r}};
  assign qtr_out_sig = {NUM_CH{drive_r}};
  assign qtr_ctrl    = {NUM_CH{ctrl_r}};

endmodule

// File: tb/tb_qtr_measure.sv
// Self-checking bench for qtr_measure, run at a 1 MHz clock to keep decay times short.
module tb_qtr_measure;

  localparam int DIV = 10;        // 1 MHz / 100 kHz
  localparam int CHG = 10;        // 1 cycle per us * 10 us
  localparam int SAT = 255 * DIV;

  typedef struct {
    int f0;
    int f1;
    int r0;
    int r1;
    bit poke;
  } vec_t;

  logic        clk, rst_n, en, busy, valid;
  logic [15:0] value;
  logic [1:0]  out_en, out_sig, pins, ctrl;
  int          n_tests, n_fail;
  int          prev0, prev1;
  bit          have;
  vec_t        tbl[8];

  qtr_measure #(
    .CLK_FREQUENCY (1_000_000),
    .NUM_CH        (2),
    .CHARGE_US     (10)
  ) dut (
    .hba_clk     (clk),
    .hba_reset_n (rst_n),
    .en          (en),
    .busy        (busy),
    .value       (value),
    .valid       (valid),
    .qtr_out_en  (out_en),
    .qtr_out_sig (out_sig),
    .qtr_in_sig  (pins),
    .qtr_ctrl    (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Pin goes low at the middle of discharge cycle f; ticks land every DIV cycles.
  function automatic int raw_count(input int f);
    int n;
    if (f < 0) return 0;
    n = (f + 2) / DIV;
    return (n > 255) ? 255 : n;
  endfunction

  function automatic int done_cycle(input int f);
    if (f < 0) return 0;
    return (f + 2 < SAT) ? f + 2 : SAT;
  endfunction

  task automatic model_next(input int r0, input int r1, output logic [15:0] e);
    int a0, a1;
    a0 = r0;
    a1 = r1;
`ifdef QTR_AVG_EN
    if (have) begin
      a0 = (prev0 + r0 + 1) / 2;
      a1 = (prev1 + r1 + 1) / 2;
    end
`endif
    prev0 = a0;
    prev1 = a1;
    have  = 1'b1;
    e = {a1[7:0], a0[7:0]};
  endtask

  task automatic run_meas(input int f0, input int f1, input int r0, input int r1,
                          input bit poke, input string tag);
    int          c, chg, lat;
    bit          seen, bad;
    logic [15:0] e;
    pins[0] = (f0 < 0) ? 1'b0 : 1'b1;
    pins[1] = (f1 < 0) ? 1'b0 : 1'b1;
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    c = 0; chg = 0;
    while (!(busy && out_en == 2'b00 && ctrl == 2'b11) && c < 200) begin
      if (busy && out_en == 2'b11 && out_sig == 2'b11 && ctrl == 2'b11) chg++;
      en = poke && (c == 3);
      @(negedge clk); c++;
    end
    en = 1'b0;
    chk({tag, " discharge_reached"}, c < 200, 1);
    chk({tag, " charge_cycles"}, chg, CHG);
    chk({tag, " discharge_pins"}, {busy, out_sig, ctrl}, {1'b1, 2'b00, 2'b11});
    c = 0; seen = 1'b0;
    while (!seen && c < 4000) begin
      if (c == f0) pins[0] = 1'b0;
      if (c == f1) pins[1] = 1'b0;
      en = poke && (c == 5);
      @(negedge clk); c++;
      if (valid) seen = 1'b1;
    end
    en = 1'b0;
    lat = (done_cycle(f0) > done_cycle(f1)) ? done_cycle(f0) : done_cycle(f1);
    chk({tag, " done_latency"}, c, lat + 1);
    model_next(r0, r1, e);
    chk({tag, " value"}, value, e);
    chk({tag, " done_outputs"}, {busy, ctrl, out_en}, {1'b1, 4'b0000});
    @(negedge clk);
    chk({tag, " idle_after_done"}, {busy, valid}, 2'b00);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || valid || value !== e) bad = 1'b1;
    end
    chk({tag, " quiet_idle_hold"}, bad, 0);
  endtask

  initial begin
    int          c, f0, f1;
    bit          bad;
    logic [15:0] e;
    n_tests = 0; n_fail = 0; have = 1'b0; prev0 = 0; prev1 = 0;
    en = 1'b0; pins = 2'b11; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("reset_state", {busy, valid, out_en, out_sig, ctrl, value}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, valid, ctrl, out_en}, 0);

    tbl[0] = '{500,    1200,   50,  120, 1'b0};
    tbl[1] = '{100000, 100000, 255, 255, 1'b0};
    tbl[2] = '{-1,     -1,     0,   0,   1'b0};
    tbl[3] = '{7,      8,      0,   1,   1'b0};
    tbl[4] = '{2547,   2548,   254, 255, 1'b0};
    tbl[5] = '{300,    900,    30,  90,  1'b1};
    tbl[6] = '{1000,   1000,   100, 100, 1'b0};
    tbl[7] = '{500,    500,    50,  50,  1'b0};

    for (int i = 0; i < 6; i++) begin
      run_meas(tbl[i].f0, tbl[i].f1, tbl[i].r0, tbl[i].r1, tbl[i].poke, $sformatf("vec%0d", i));
    end

    // Reset in the middle of DISCHARGE aborts the measurement.
    pins = 2'b11;
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    c = 0;
    while (!(busy && out_en == 2'b00 && ctrl == 2'b11) && c < 200) begin
      @(negedge clk); c++;
    end
    chk("rst_discharge_reached", c < 200, 1);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_discharge_outputs", {busy, valid, out_en, out_sig, ctrl, value}, 0);
    have = 1'b0; prev0 = 0; prev1 = 0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (valid || busy) bad = 1'b1;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (valid || busy) bad = 1'b1;
    end
    chk("rst_no_valid", bad, 0);

    for (int i = 6; i < 8; i++) begin
      run_meas(tbl[i].f0, tbl[i].f1, tbl[i].r0, tbl[i].r1, tbl[i].poke, $sformatf("vec%0d", i));
    end

    // en held high: back-to-back runs separated by a single IDLE cycle.
    pins = 2'b00;
    @(negedge clk); en = 1'b1;
    c = 0;
    while (!valid && c < 100) begin
      @(negedge clk); c++;
    end
    chk("b2b_first_valid", c < 100, 1);
    model_next(0, 0, e);
    chk("b2b_first_value", value, e);
    @(negedge clk);
    chk("b2b_idle_gap", {busy, valid}, 2'b00);
    @(negedge clk);
    chk("b2b_restart", {busy, out_en}, {1'b1, 2'b11});
    c = 2;
    while (!valid && c < 100) begin
      @(negedge clk); c++;
    end
    chk("b2b_period", c, CHG + 3);
    model_next(0, 0, e);
    chk("b2b_second_value", value, e);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_stops", {busy, valid}, 2'b00);

    for (int i = 0; i < 8; i++) begin
      f0 = int'($urandom_range(0, 2700));
      f1 = int'($urandom_range(0, 2700));
      run_meas(f0, f1, raw_count(f0), raw_count(f1), 1'b0, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qtr_measure.md
QTR_MEASURE -- requirements
Module: qtr_measure

Interface
REQ-001 Parameter CLK_FREQUENCY, default 60_000_000, hba_clk frequency in Hz.
REQ-002 Parameter NUM_CH, default 2, number of QTR sensor channels.
REQ-003 Parameter CHARGE_US, default 10, capacitor charge time in microseconds.
REQ-004 hba_clk  input  1  sole clock, rising edge.
REQ-005 hba_reset_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  start-measurement request, sampled on hba_clk.
REQ-007 busy  output  1  measurement in progress.
REQ-008 value  output  NUM_CH*8  per-channel decay time in 10 us units; channel k at bits [8k+7:8k].
REQ-009 valid  output  1  one-cycle strobe; value updated in the same cycle.
REQ-010 qtr_out_en  output  NUM_CH  pin output-enable; 1 = drive.
REQ-011 qtr_out_sig  output  NUM_CH  pin drive value.
REQ-012 qtr_in_sig  input  NUM_CH  asynchronous pin readback.
REQ-013 qtr_ctrl  output  NUM_CH  emitter LED enable.

Function
REQ-014 Each qtr_in_sig bit SHALL pass a 2-flop synchronizer before use.
REQ-015 The FSM SHALL have states IDLE, CHARGE, DISCHARGE, DONE.
REQ-016 IDLE: all pin outputs 0, busy 0; en=1 -> CHARGE next cycle.
REQ-017 en SHALL be ignored in every state except IDLE.
REQ-018 CHARGE: qtr_ctrl, qtr_out_en, qtr_out_sig all 1, busy 1, for exactly (CLK_FREQUENCY/1_000_000)*CHARGE_US cycles, then -> DISCHARGE.
REQ-019 DISCHARGE: qtr_out_en=0, qtr_out_sig=0, qtr_ctrl=1, busy=1.
REQ-020 A 10 us tick SHALL strobe every CLK_FREQUENCY/100_000 cycles, phase restarted on DISCHARGE entry.
REQ-021 Per channel: 8-bit counter cleared on DISCHARGE entry; increments on each tick while synchronized input is 1 and the channel is not done.
REQ-022 Channel done when synchronized input is 0 (count frozen) or count reaches 255 (saturates, never wraps).
REQ-023 All channels done -> DONE; done channels stay frozen while others continue.
REQ-024 DONE (one cycle): value loaded, valid=1, qtr_ctrl=0, busy=1; -> IDLE.
REQ-025 en held high continuously SHALL yield back-to-back measurements separated by one IDLE cycle.
REQ-026 value SHALL hold its last result between valid strobes.

Reset
REQ-027 hba_reset_n low SHALL immediately force IDLE, value=0, valid=0, busy=0, qtr_out_en=0, qtr_out_sig=0, qtr_ctrl=0, counters and synchronizers 0.
REQ-028 Reset asserted mid-measurement SHALL abort it with no valid strobe; the first en after release starts a fresh measurement.

Configuration
REQ-029 Macro QTR_AVG_EN defined: on DONE each channel value = (previous value + new count + 1) >> 1 using a 9-bit intermediate; the first result after reset loads the raw count.
REQ-030 QTR_AVG_EN undefined: value = raw count; no averaging logic present.

Structure
REQ-031 Package qtr_pkg SHALL hold the FSM state encoding, TICK_10US_DIV derivation, COUNT_MAX=255.
REQ-032 Sub-module qtr_tick_gen (restartable 10 us strobe generator) SHALL be instantiated once and shared by all channels.

Verification
REQ-033 CLK_FREQUENCY=60e6, ch0 input falls 500 us into DISCHARGE, ch1 at 1.2 ms -> value={8'd120,8'd50} ±1, one valid pulse.
REQ-034 Inputs stuck high -> both channels 255 at 2.55 ms, valid pulses, FSM returns to IDLE.
REQ-035 Inputs low before DISCHARGE -> value=0, DONE reached within 3 cycles plus sync latency.
REQ-036 en pulsed during CHARGE and DISCHARGE -> no extra measurement, exactly one valid.
REQ-037 hba_reset_n low mid-DISCHARGE -> all outputs 0 in the same cycle, no valid; next en measures normally.
REQ-038 QTR_AVG_EN defined, raw counts 100 then 50 -> value 100 then 75.
